// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier: retires one multiplier bit per clock, signed or unsigned,
// with a start/busy/done handshake and a product register held until the next completion.
module seq_multiplier #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [0:0] {StIdle, StCalc} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic [CW-1:0]      cnt_q;
    logic               neg_q;
    logic               done_q;
    logic [2*WIDTH-1:0] product_q;

    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] result;
    logic               last;

    // The most-negative operand negates to itself, which is its correct unsigned magnitude.
    always_comb begin
        mag_a = (signed_mode && multiplicand[WIDTH-1]) ? (~multiplicand + 1'b1) : multiplicand;
        mag_b = (signed_mode && multiplier[WIDTH-1]) ? (~multiplier + 1'b1) : multiplier;
    end

    always_comb begin
        sum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : {(WIDTH + 1){1'b0}});
        result = {sum, lo_q[WIDTH-1:1]};
        last   = (cnt_q == CW'(WIDTH - 1));
    end

    // State register
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (start) state_d = StCalc;
            StCalc: if (last) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath
    always_ff @(posedge clock) begin
        if (!reset) begin
            mcand_q   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        mcand_q <= mag_a;
                        lo_q    <= mag_b;
                        hi_q    <= '0;
                        cnt_q   <= '0;
                        neg_q   <= signed_mode & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
                    end
                end
                StCalc: begin
                    hi_q  <= sum[WIDTH:1];
                    lo_q  <= {sum[0], lo_q[WIDTH-1:1]};
                    cnt_q <= cnt_q + CW'(1);
                    if (last) begin
                        product_q <= neg_q ? (~result + 1'b1) : result;
                        done_q    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs
    always_comb begin
        busy    = (state_q == StCalc);
        done    = done_q;
        product = product_q;
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed self-checking bench for seq_multiplier at WIDTH=8 and WIDTH=16.
module tb_seq_multiplier;

    logic        clock;
    logic        reset;
    logic        start8, sm8, busy8, done8;
    logic [7:0]  a8, b8;
    logic [15:0] product8;
    logic        start16, sm16, busy16, done16;
    logic [15:0] a16, b16;
    logic [31:0] product16;

    int pass_cnt;
    int total_cnt;

    logic [15:0] p8;
    logic [31:0] p16;
    int          lat;
    int          bcnt;

    seq_multiplier #(.WIDTH(8)) dut8 (
        .clock(clock), .reset(reset), .start(start8), .signed_mode(sm8),
        .multiplicand(a8), .multiplier(b8),
        .busy(busy8), .done(done8), .product(product8)
    );

    seq_multiplier #(.WIDTH(16)) dut16 (
        .clock(clock), .reset(reset), .start(start16), .signed_mode(sm16),
        .multiplicand(a16), .multiplier(b16),
        .busy(busy16), .done(done16), .product(product16)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Pulse start for one cycle and wait for done; lat counts edges after the start edge.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic sm);
        @(negedge clock);
        a8 = a; b8 = b; sm8 = sm; start8 = 1'b1;
        @(negedge clock);
        start8 = 1'b0;
        lat = 0; bcnt = 0;
        while (!done8 && lat < 40) begin
            if (busy8) bcnt++;
            @(negedge clock);
            lat++;
        end
        p8 = product8;
    endtask

    task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic sm);
        @(negedge clock);
        a16 = a; b16 = b; sm16 = sm; start16 = 1'b1;
        @(negedge clock);
        start16 = 1'b0;
        lat = 0; bcnt = 0;
        while (!done16 && lat < 60) begin
            if (busy16) bcnt++;
            @(negedge clock);
            lat++;
        end
        p16 = product16;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clock);
        total_cnt++;
        if (busy8 !== 1'b0) $display("FAIL reset_busy8 got %b want 0", busy8);
        else pass_cnt++;
        total_cnt++;
        if (done8 !== 1'b0) $display("FAIL reset_done8 got %b want 0", done8);
        else pass_cnt++;
        total_cnt++;
        if (product8 !== 16'h0000) $display("FAIL reset_product8 got %h want 0000", product8);
        else pass_cnt++;
        total_cnt++;
        if (product16 !== 32'h0 || busy16 !== 1'b0 || done16 !== 1'b0)
            $display("FAIL reset_dut16 got p=%h b=%b d=%b want 0/0/0", product16, busy16, done16);
        else pass_cnt++;
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_unsigned();
        run8(8'hFF, 8'hFF, 1'b0);
        total_cnt++;
        if (p8 !== 16'hFE01) $display("FAIL u_255x255 got %h want fe01", p8);
        else pass_cnt++;
        total_cnt++;
        if (lat !== 8) $display("FAIL u_latency got %0d want 8", lat);
        else pass_cnt++;
        total_cnt++;
        if (bcnt !== 8) $display("FAIL u_busy_cycles got %0d want 8", bcnt);
        else pass_cnt++;
        @(negedge clock);
        total_cnt++;
        if (done8 !== 1'b0 || busy8 !== 1'b0)
            $display("FAIL u_done_pulse got d=%b b=%b want 0/0", done8, busy8);
        else pass_cnt++;
        repeat (3) @(negedge clock);
        total_cnt++;
        if (product8 !== 16'hFE01) $display("FAIL u_hold got %h want fe01", product8);
        else pass_cnt++;
    endtask

    task automatic test_signed();
        run8(8'hFD, 8'h05, 1'b1);
        total_cnt++;
        if (p8 !== 16'hFFF1) $display("FAIL s_m3x5 got %h want fff1", p8);
        else pass_cnt++;
        run8(8'hFF, 8'hFF, 1'b1);
        total_cnt++;
        if (p8 !== 16'h0001) $display("FAIL s_m1xm1 got %h want 0001", p8);
        else pass_cnt++;
        run8(8'hFF, 8'hFF, 1'b0);
        total_cnt++;
        if (p8 !== 16'hFE01) $display("FAIL u_ffxff got %h want fe01", p8);
        else pass_cnt++;
        run8(8'h05, 8'hFD, 1'b1);
        total_cnt++;
        if (p8 !== 16'hFFF1) $display("FAIL s_5xm3 got %h want fff1", p8);
        else pass_cnt++;
    endtask

    task automatic test_min_neg();
        run8(8'h80, 8'h80, 1'b1);
        total_cnt++;
        if (p8 !== 16'h4000) $display("FAIL s_m128xm128 got %h want 4000", p8);
        else pass_cnt++;
        run8(8'h80, 8'h7F, 1'b1);
        total_cnt++;
        if (p8 !== 16'hC080) $display("FAIL s_m128x127 got %h want c080", p8);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int ndone;
        int e1;
        int e2;
        logic [15:0] q1;
        logic [15:0] q2;
        ndone = 0; e1 = -1; e2 = -1; q1 = '0; q2 = '0;
        @(negedge clock);
        a8 = 8'd12; b8 = 8'd10; sm8 = 1'b0; start8 = 1'b1;
        for (int e = 0; e <= 20; e++) begin
            @(negedge clock);
            if (done8) begin
                ndone++;
                if (ndone == 1) begin e1 = e; q1 = product8; end
                if (ndone == 2) begin e2 = e; q2 = product8; end
            end
            if (e == 19) start8 = 1'b0;
        end
        total_cnt++;
        if (ndone !== 2) $display("FAIL hs_count got %0d want 2", ndone);
        else pass_cnt++;
        total_cnt++;
        if (e1 !== 8 || e2 !== 17) $display("FAIL hs_timing got %0d,%0d want 8,17", e1, e2);
        else pass_cnt++;
        total_cnt++;
        if (q1 !== 16'd120 || q2 !== 16'd120)
            $display("FAIL hs_products got %0d,%0d want 120,120", q1, q2);
        else pass_cnt++;
        // Drain the operation accepted at the end of the held-start window.
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            if (done8) break;
        end
        @(negedge clock);

        // start with new operands mid-operation must be ignored.
        @(negedge clock);
        a8 = 8'd12; b8 = 8'd10; sm8 = 1'b0; start8 = 1'b1;
        @(negedge clock);
        start8 = 1'b0;
        lat = 0;
        while (!done8 && lat < 40) begin
            if (lat == 3) begin a8 = 8'd99; b8 = 8'd77; sm8 = 1'b1; start8 = 1'b1; end
            else start8 = 1'b0;
            @(negedge clock);
            lat++;
        end
        start8 = 1'b0;
        total_cnt++;
        if (product8 !== 16'd120 || lat !== 8)
            $display("FAIL hs_midcalc got p=%0d lat=%0d want 120/8", product8, lat);
        else pass_cnt++;
        @(negedge clock);
        total_cnt++;
        if (busy8 !== 1'b0) $display("FAIL hs_no_queue got busy=%b want 0", busy8);
        else pass_cnt++;
    endtask

    task automatic test_reset_abort();
        int seen;
        @(negedge clock);
        a8 = 8'd200; b8 = 8'd3; sm8 = 1'b0; start8 = 1'b1;
        @(negedge clock);
        start8 = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        total_cnt++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || product8 !== 16'h0)
            $display("FAIL abort_state got b=%b d=%b p=%h want 0/0/0000", busy8, done8, product8);
        else pass_cnt++;
        reset = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clock);
            if (done8) seen++;
        end
        total_cnt++;
        if (seen !== 0) $display("FAIL abort_no_done got %0d pulses want 0", seen);
        else pass_cnt++;
        run8(8'd7, 8'd6, 1'b0);
        total_cnt++;
        if (p8 !== 16'd42) $display("FAIL abort_restart got %0d want 42", p8);
        else pass_cnt++;
    endtask

    task automatic test_wide();
        run16(16'hFFFF, 16'hFFFF, 1'b0);
        total_cnt++;
        if (p16 !== 32'hFFFE0001) $display("FAIL w16_ffff got %h want fffe0001", p16);
        else pass_cnt++;
        total_cnt++;
        if (lat !== 16) $display("FAIL w16_latency got %0d want 16", lat);
        else pass_cnt++;
        run16(16'h8000, 16'h0002, 1'b1);
        total_cnt++;
        if (p16 !== 32'hFFFF0000) $display("FAIL w16_signed got %h want ffff0000", p16);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt = 0; total_cnt = 0;
        reset = 1'b0;
        start8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
        start16 = 1'b0; sm16 = 1'b0; a16 = '0; b16 = '0;
        test_reset();
        test_unsigned();
        test_signed();
        test_min_neg();
        test_back_to_back();
        test_reset_abort();
        test_wide();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
